// File: rtl/piano_key_renderer.sv
// Polyphonic PS/2 piano key tracker with per-key release glow and a
// two-stage keyboard pixel renderer for the VGA path.
module piano_key_renderer #(
    parameter int OCTAVES     = 3,
    parameter int HOLD_FRAMES = 8,
    parameter int HOLD_W      = 4,
    parameter int X0          = 5,
    parameter int Y_TOP       = 140,
    parameter int Y_SPLIT     = 274,
    parameter int Y_BOT       = 340,
    localparam int NK         = 12 * OCTAVES
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    scan_code,
    input  logic          scan_valid,
    input  logic          frame_tick,
    input  logic [9:0]    px_x,
    input  logic [9:0]    px_y,
    input  logic          px_valid,
    output logic [9:0]    red,
    output logic [9:0]    green,
    output logic [9:0]    blue,
    output logic          rgb_valid,
    output logic [NK-1:0] key_down
);
    localparam int IW = $clog2(NK);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    localparam logic [7:0] SCAN_MAP [36] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h4A
    };

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BREAK     = 2'd1;
    localparam logic [1:0] S_EXT       = 2'd2;
    localparam logic [1:0] S_EXT_BREAK = 2'd3;

    localparam logic [2:0] C_BG     = 3'd0;
    localparam logic [2:0] C_BORDER = 3'd1;
    localparam logic [2:0] C_BLACK  = 3'd2;
    localparam logic [2:0] C_SEP    = 3'd3;
    localparam logic [2:0] C_WHITE  = 3'd4;

    localparam logic [9:0] X0_L  = 10'(X0);
    localparam logic [9:0] YT_L  = 10'(Y_TOP);
    localparam logic [9:0] YS_L  = 10'(Y_SPLIT);
    localparam logic [9:0] YB_L  = 10'(Y_BOT);
    localparam logic [9:0] KBW_L = 10'(210 * OCTAVES);

    localparam logic [29:0] RGB_BG     = {10'h314, 10'h314, 10'h3FB};
    localparam logic [29:0] RGB_BORDER = {10'h214, 10'h114, 10'h3AB};
    localparam logic [29:0] RGB_WHITE  = {10'h3FF, 10'h3FF, 10'h3FF};
    localparam logic [29:0] RGB_ON     = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] RGB_GLOW   = {10'h000, 10'h1FF, 10'h000};

    logic [1:0]                   state_q, state_d;
    logic [NK-1:0]                down_q, down_d;
    logic [NK-1:0][HOLD_W-1:0]    hold_q, hold_d;
    logic [NK-1:0]                hit_vec;
    logic                         do_make, do_break;

    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < NK; i++)
            hit_vec[i] = (scan_code == SCAN_MAP[i]);
    end

    assign do_make  = scan_valid && (state_q == S_IDLE);
    assign do_break = scan_valid && (state_q == S_BREAK);

    always_comb begin
        state_d = state_q;
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hF0)      state_d = S_BREAK;
                    else if (scan_code == 8'hE0) state_d = S_EXT;
                end
                S_EXT:   state_d = (scan_code == 8'hF0) ? S_EXT_BREAK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame decrement first; a make/break on the same key overrides it.
    always_comb begin
        down_d = down_q;
        hold_d = hold_q;
        for (int unsigned i = 0; i < NK; i++) begin
            if (frame_tick && hold_q[i] != '0)
                hold_d[i] = hold_q[i] - HOLD_ONE;
            if (do_make && hit_vec[i]) begin
                down_d[i] = 1'b1;
                hold_d[i] = '0;
            end
            if (do_break && hit_vec[i]) begin
                down_d[i] = 1'b0;
                hold_d[i] = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            down_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            down_q  <= down_d;
            hold_q  <= hold_d;
        end
    end

    assign key_down = down_q;

    logic [9:0]    r, rr, rm;
    logic [1:0]    oct;
    logic [2:0]    wi;
    logic [3:0]    bsemi, wsemi, ksemi;
    logic          black;
    logic [5:0]    key6;
    logic [2:0]    cls_d, cls_q;
    logic [IW-1:0] key_d, key_q;
    logic          v1_q;

    always_comb begin
        r = px_x - X0_L;
        if (r >= 10'd420)      begin oct = 2'd2; rr = r - 10'd420; end
        else if (r >= 10'd210) begin oct = 2'd1; rr = r - 10'd210; end
        else                   begin oct = 2'd0; rr = r;            end

        if (rr < 10'd30)       wi = 3'd0;
        else if (rr < 10'd60)  wi = 3'd1;
        else if (rr < 10'd90)  wi = 3'd2;
        else if (rr < 10'd120) wi = 3'd3;
        else if (rr < 10'd150) wi = 3'd4;
        else if (rr < 10'd180) wi = 3'd5;
        else                   wi = 3'd6;
        rm = rr - 10'd30 * {7'd0, wi};

        black = 1'b1;
        if (rr >= 10'd20 && rr <= 10'd39)        bsemi = 4'd1;
        else if (rr >= 10'd50 && rr <= 10'd69)   bsemi = 4'd3;
        else if (rr >= 10'd110 && rr <= 10'd129) bsemi = 4'd6;
        else if (rr >= 10'd140 && rr <= 10'd159) bsemi = 4'd8;
        else if (rr >= 10'd170 && rr <= 10'd189) bsemi = 4'd10;
        else begin
            bsemi = 4'd0;
            black = 1'b0;
        end
        black = black && (px_y < YS_L);

        case (wi)
            3'd0:    wsemi = 4'd0;
            3'd1:    wsemi = 4'd2;
            3'd2:    wsemi = 4'd4;
            3'd3:    wsemi = 4'd5;
            3'd4:    wsemi = 4'd7;
            3'd5:    wsemi = 4'd9;
            default: wsemi = 4'd11;
        endcase
        ksemi = black ? bsemi : wsemi;
        key6  = 6'd12 * {4'd0, oct} + {2'd0, ksemi};
        key_d = IW'(key6);

        if (px_y < YT_L || px_y > YB_L)                     cls_d = C_BG;
        else if (px_x < X0_L || r >= KBW_L)                 cls_d = C_BORDER;
        else if (black)                                     cls_d = C_BLACK;
        else if (rm == 10'd29 || (rm == 10'd0 && r != '0))  cls_d = C_SEP;
        else                                                cls_d = C_WHITE;
    end

    logic [29:0] rgb_d, rgb_q;
    logic        v2_q;

    // Stage 2 samples live key state so updates reach pixels already in flight.
    always_comb begin
        case (cls_q)
            C_BG:     rgb_d = RGB_BG;
            C_BORDER: rgb_d = RGB_BORDER;
            C_WHITE:  rgb_d = RGB_WHITE;
            default:  rgb_d = '0;
        endcase
        if (cls_q == C_BLACK || cls_q == C_WHITE) begin
            if (down_q[key_q])              rgb_d = RGB_ON;
            else if (hold_q[key_q] != '0)   rgb_d = RGB_GLOW;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cls_q <= C_BG;
            key_q <= '0;
            v1_q  <= 1'b0;
            rgb_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            cls_q <= cls_d;
            key_q <= key_d;
            v1_q  <= px_valid;
            rgb_q <= rgb_d;
            v2_q  <= v1_q;
        end
    end

    assign red       = rgb_q[29:20];
    assign green     = rgb_q[19:10];
    assign blue      = rgb_q[9:0];
    assign rgb_valid = v2_q;

endmodule

// File: tb/tb_piano_key_renderer.sv
// Bench for piano_key_renderer: a 3-octave/8-frame instance and a 2-octave/no-glow
// instance share stimulus; directed tables plus a randomized run against a model.
module tb_piano_key_renderer;
    localparam logic [29:0] BG     = {10'h314, 10'h314, 10'h3FB};
    localparam logic [29:0] BORDER = {10'h214, 10'h114, 10'h3AB};
    localparam logic [29:0] WHITE  = {10'h3FF, 10'h3FF, 10'h3FF};
    localparam logic [29:0] BLACK  = 30'h0;
    localparam logic [29:0] ON     = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] GLOW   = {10'h000, 10'h1FF, 10'h000};

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  scan_code;
    logic        scan_valid, frame_tick, px_valid;
    logic [9:0]  px_x, px_y;
    logic [9:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        rgb_valid_a, rgb_valid_b;
    logic [35:0] key_down_a;
    logic [23:0] key_down_b;
    logic [29:0] rgb_a, rgb_b;

    always #5 clk = ~clk;

    assign rgb_a = {red_a, green_a, blue_a};
    assign rgb_b = {red_b, green_b, blue_b};

    piano_key_renderer dut_a (
        .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
        .frame_tick(frame_tick), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .red(red_a), .green(green_a), .blue(blue_a), .rgb_valid(rgb_valid_a),
        .key_down(key_down_a)
    );

    piano_key_renderer #(.OCTAVES(2), .HOLD_FRAMES(0)) dut_b (
        .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
        .frame_tick(frame_tick), .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .red(red_b), .green(green_b), .blue(blue_b), .rgb_valid(rgb_valid_b),
        .key_down(key_down_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: key state per instance, prefix bytes of a pending sequence.
    logic [7:0] scan_tbl [36] = '{
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h4A
    };
    int         wsemi_tbl [7] = '{0, 2, 4, 5, 7, 9, 11};
    int         octs  [2] = '{3, 2};
    int         holdf [2] = '{8, 0};
    bit         mdl_down [2][36];
    int         mdl_hold [2][36];
    logic [7:0] prefix [$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 36; i++) begin
                mdl_down[d][i] = 1'b0;
                mdl_hold[d][i] = 0;
            end
        prefix.delete();
    endtask

    function automatic int key_of(int d, logic [7:0] c);
        for (int i = 0; i < 12 * octs[d]; i++)
            if (scan_tbl[i] == c) return i;
        return -1;
    endfunction

    task automatic model_step(bit sv, logic [7:0] c, bit ft);
        int k;
        if (ft)
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 36; i++)
                    if (mdl_hold[d][i] > 0) mdl_hold[d][i]--;
        if (sv) begin
            if (prefix.size() == 0 && (c == 8'hF0 || c == 8'hE0))
                prefix.push_back(c);
            else if (prefix.size() == 1 && prefix[0] == 8'hE0 && c == 8'hF0)
                prefix.push_back(c);
            else begin
                for (int d = 0; d < 2; d++) begin
                    k = key_of(d, c);
                    if (k >= 0 && prefix.size() == 0) begin
                        mdl_down[d][k] = 1'b1;
                        mdl_hold[d][k] = 0;
                    end else if (k >= 0 && prefix.size() == 1 && prefix[0] == 8'hF0) begin
                        mdl_down[d][k] = 1'b0;
                        mdl_hold[d][k] = holdf[d];
                    end
                end
                prefix.delete();
            end
        end
    endtask

    function automatic logic [35:0] model_kd(int d);
        logic [35:0] v = '0;
        for (int i = 0; i < 12 * octs[d]; i++) v[i] = mdl_down[d][i];
        return v;
    endfunction

    function automatic logic [29:0] model_rgb(int d, int x, int y);
        int r, rr, m, semi, key;
        logic [29:0] idle;
        if (y < 140 || y > 340) return BG;
        if (x < 5 || x - 5 >= 210 * octs[d]) return BORDER;
        r = x - 5; rr = r % 210; m = r % 30;
        semi = -1;
        if (y < 274) begin
            if (rr >= 20 && rr <= 39)        semi = 1;
            else if (rr >= 50 && rr <= 69)   semi = 3;
            else if (rr >= 110 && rr <= 129) semi = 6;
            else if (rr >= 140 && rr <= 159) semi = 8;
            else if (rr >= 170 && rr <= 189) semi = 10;
        end
        if (semi < 0) begin
            if (m == 29 || (m == 0 && r != 0)) return BLACK;
            semi = wsemi_tbl[rr / 30];
            idle = WHITE;
        end else idle = BLACK;
        key = 12 * (r / 210) + semi;
        if (mdl_down[d][key]) return ON;
        if (mdl_hold[d][key] != 0) return GLOW;
        return idle;
    endfunction

    task automatic send(input logic [7:0] b, input bit ft = 1'b0);
        @(negedge clk);
        scan_code = b; scan_valid = 1'b1; frame_tick = ft;
        @(negedge clk);
        scan_valid = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
    endtask

    logic        early_v;
    logic [29:0] got_a, got_b;
    logic        got_va;

    task automatic probe(input int x, input int y);
        @(negedge clk);
        px_x = 10'(x); px_y = 10'(y); px_valid = 1'b1;
        @(negedge clk);
        px_valid = 1'b0;
        early_v = rgb_valid_a;
        @(negedge clk);
        got_a = rgb_a; got_b = rgb_b; got_va = rgb_valid_a;
    endtask

    typedef struct {
        string       name;
        int          x;
        int          y;
        logic [29:0] exp_a;
        logic [29:0] exp_b;
    } pvec_t;
    pvec_t vecs [$];

    task automatic add_vec(input string n, input int x, input int y,
                           input logic [29:0] a, input logic [29:0] b);
        pvec_t v;
        v.name = n; v.x = x; v.y = y; v.exp_a = a; v.exp_b = b;
        vecs.push_back(v);
    endtask

    bit          r_sv, r_ft, r_pv, prev_v;
    logic [7:0]  r_code;
    int          r_x, r_y, prev_x, prev_y;

    function automatic logic [7:0] pick_code();
        int sel = $urandom_range(0, 9);
        if (sel < 5) return scan_tbl[$urandom_range(0, 35)];
        if (sel < 7) return 8'hF0;
        if (sel < 8) return 8'hE0;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; scan_code = '0; scan_valid = 1'b0; frame_tick = 1'b0;
        px_x = 10'd30; px_y = 10'd200; px_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_kd_a", key_down_a, 0);
        check("reset_kd_b", key_down_b, 0);
        check("reset_valid_a", rgb_valid_a, 0);
        check("reset_rgb_a", rgb_a, 0);
        px_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        send(8'h1E);
        check("make1E_kd_a", key_down_a, 36'h2);
        check("make1E_kd_b", key_down_b, 24'h2);

        add_vec("csharp_on",    30, 200, ON,     ON);
        add_vec("c_white",      20, 300, WHITE,  WHITE);
        add_vec("bg_above",      5, 100, BG,     BG);
        add_vec("bg_row139",    30, 139, BG,     BG);
        add_vec("top_row140",   30, 140, ON,     ON);
        add_vec("row273",       30, 273, ON,     ON);
        add_vec("split274",     30, 274, WHITE,  WHITE);
        add_vec("bot_row340",   30, 340, WHITE,  WHITE);
        add_vec("bg_row341",    30, 341, BG,     BG);
        add_vec("border_left",   4, 300, BORDER, BORDER);
        add_vec("x0_edge",       5, 300, WHITE,  WHITE);
        add_vec("sep_29",       34, 300, BLACK,  BLACK);
        add_vec("sep_30",       35, 300, BLACK,  BLACK);
        add_vec("d_white",      36, 300, WHITE,  WHITE);
        add_vec("dsharp_idle",  60, 200, BLACK,  BLACK);
        add_vec("oct1_csharp", 240, 200, BLACK,  BLACK);
        add_vec("sep_419",     424, 300, BLACK,  BLACK);
        add_vec("sep_420",     425, 300, BLACK,  BORDER);
        add_vec("last_col",    634, 300, BLACK,  BORDER);
        add_vec("border_right",635, 300, BORDER, BORDER);
        foreach (vecs[i]) begin
            probe(vecs[i].x, vecs[i].y);
            check({"vec_a ", vecs[i].name}, {early_v, got_va, got_a}, {1'b0, 1'b1, vecs[i].exp_a});
            check({"vec_b ", vecs[i].name}, got_b, vecs[i].exp_b);
        end

        send(8'h16); send(8'h4A);
        check("poly_kd_a", key_down_a, 36'h800000003);
        check("poly_kd_b", key_down_b, 24'h3);
        probe(20, 300);
        check("poly_c_a", got_a, ON);
        check("poly_c_b", got_b, ON);
        probe(620, 300);
        check("poly_b35_a", got_a, ON);
        check("poly_b35_b", got_b, BORDER);

        send(8'hF0); send(8'h1E);
        check("break_kd_a", key_down_a, 36'h800000001);
        probe(30, 200);
        check("glow_start_a", got_a, GLOW);
        check("noglow_b", got_b, BLACK);
        ticks(7);
        probe(30, 200);
        check("glow_7_a", got_a, GLOW);
        ticks(1);
        probe(30, 200);
        check("glow_8_a", got_a, BLACK);

        send(8'hF0); send(8'h1E, 1'b1);
        probe(30, 200);
        check("coinc_glow_a", got_a, GLOW);
        ticks(7);
        probe(30, 200);
        check("coinc_7_a", got_a, GLOW);
        ticks(1);
        probe(30, 200);
        check("coinc_8_a", got_a, BLACK);

        send(8'h1E);
        send(8'hE0); send(8'hF0); send(8'h1E);
        check("ext_break_kd_a", key_down_a, 36'h800000003);
        send(8'hF0); send(8'h1E);
        send(8'hE0); send(8'h1E);
        check("ext_make_kd_a", key_down_a, 36'h800000001);
        send(8'h25);
        check("after_ext_kd_a", key_down_a, 36'h800000009);

        send(8'h1C);
        check("oct2_kd_b", key_down_b, 24'h9);
        check("oct2_kd_a", key_down_a, 36'h801000009);
        probe(500, 300);
        check("x500_b", got_b, BORDER);
        check("x500_a", got_a, WHITE);
        probe(5, 100);
        check("bg_b", got_b, BG);

        send(8'hF0); send(8'h25);
        send(8'hF0);
        @(negedge clk);
        px_x = 10'd60; px_y = 10'd200; px_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        check("pre_rst_glow_a", rgb_a, GLOW);
        #2 resetn = 1'b0;
        #1;
        check("async_kd_a", key_down_a, 0);
        check("async_kd_b", key_down_b, 0);
        check("async_rgb_a", rgb_a, 0);
        check("async_valid_a", rgb_valid_a, 0);
        px_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        send(8'h16);
        check("post_rst_kd_a", key_down_a, 36'h1);
        probe(60, 200);
        check("post_rst_dsharp_a", got_a, BLACK);
        probe(34, 300);
        check("post_rst_sep_a", got_a, BLACK);

        resetn = 1'b0;
        @(negedge clk); @(negedge clk);
        model_reset();
        resetn = 1'b1;
        prev_v = 1'b0; prev_x = 0; prev_y = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            r_sv = ($urandom_range(0, 2) == 0);
            r_code = pick_code();
            r_ft = ($urandom_range(0, 7) == 0);
            r_pv = ($urandom_range(0, 3) != 0);
            r_x = $urandom_range(0, 700);
            r_y = $urandom_range(120, 360);
            scan_valid = r_sv; scan_code = r_code; frame_tick = r_ft;
            px_valid = r_pv; px_x = 10'(r_x); px_y = 10'(r_y);
            @(posedge clk); #1;
            check($sformatf("rnd_valid c%0d", c), rgb_valid_a, prev_v);
            if (prev_v) begin
                check($sformatf("rnd_rgb_a c%0d (%0d,%0d)", c, prev_x, prev_y),
                      rgb_a, model_rgb(0, prev_x, prev_y));
                check($sformatf("rnd_rgb_b c%0d (%0d,%0d)", c, prev_x, prev_y),
                      rgb_b, model_rgb(1, prev_x, prev_y));
            end
            model_step(r_sv, r_code, r_ft);
            check($sformatf("rnd_kd_a c%0d", c), key_down_a, model_kd(0));
            check($sformatf("rnd_kd_b c%0d", c), key_down_b, model_kd(1));
            prev_v = r_pv; prev_x = r_x; prev_y = r_y;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/piano_key_renderer.md
Name: piano_key_renderer

Overview:
- Next-generation keyboard visualiser for the synth VGA path. It consumes the raw PS/2 scan-code byte stream and tracks make/break state for up to 36 piano keys (polyphonic).
- Each released key keeps a per-key release glow for a programmable number of frames.
- Colours are produced for a parametrised number of octaves through a registered 2-stage pixel pipeline feeding the VGA controller.

Parameters:
OCTAVES, 3, octaves drawn and tracked (1..3); 12 keys each, NK = 12*OCTAVES
HOLD_FRAMES, 8, release-glow length in frames; 0 disables glow
HOLD_W, 4, hold counter width; HOLD_FRAMES < 2**HOLD_W
X0, 5, left x of keyboard
Y_TOP, 140, first keyboard row
Y_SPLIT, 274, first white-only row
Y_BOT, 340, last keyboard row

Ports:
clk  in  1  pixel/system clock
resetn  in  1  asynchronous active-low reset
scan_code  in  8  PS/2 byte
scan_valid  in  1  one-cycle strobe, scan_code valid
frame_tick  in  1  one-cycle strobe per frame
px_x  in  10  pixel column
px_y  in  10  pixel row
px_valid  in  1  pixel coordinate valid
red  out  10  pixel red
green  out  10  pixel green
blue  out  10  pixel blue
rgb_valid  out  1  px_valid delayed 2 cycles
key_down  out  NK  live pressed bitmap, bit i = key index i

Behaviour:
- Reset (async, resetn=0):
  - key_down, all hold counters, pipeline registers, red/green/blue and rgb_valid go to 0.
  - Decoder goes to S_IDLE.
  - Reset mid-glow or mid-sequence discards all state.
- Key index = 12*octave + semitone (C=0 .. B=11). Scan map, semitone order:
  - oct0: 16,1E,26,25,2E,36,3D,3E,46,45,4E,55
  - oct1: 15,1D,24,2D,2C,35,3C,43,44,4D,54,5B
  - oct2: 1C,1B,23,2B,34,33,3B,42,4B,4C,52,4A
  - Codes mapping to an index >= NK are unmapped.
- Decoder FSM (advances only on scan_valid):
  - S_IDLE:
    - F0 -> S_BREAK.
    - E0 -> S_EXT.
    - Mapped code -> set key_down[i] and clear hold[i]; stay in S_IDLE.
    - Other codes are ignored.
  - S_BREAK:
    - Mapped code -> clear key_down[i] and load hold[i] = HOLD_FRAMES.
    - Any byte -> S_IDLE.
  - S_EXT: F0 -> S_EXT_BREAK; any other byte -> S_IDLE (ignored).
  - S_EXT_BREAK: any byte -> S_IDLE (ignored).
- key_down timing and repeats:
  - key_down updates the cycle after the final byte's scan_valid.
  - Typematic repeats of a held key are idempotent.
  - A break for a key not down still loads its hold counter.
- Hold counters:
  - On frame_tick, every nonzero hold[i] decrements by 1. Counters saturate at 0.
  - A load or clear in the same cycle as frame_tick wins over the decrement.
- Renderer geometry: r = px_x - X0, rr = r mod 210, keyboard width W = 210*OCTAVES.
  - y < Y_TOP or y > Y_BOT: background 314/314/3FB.
  - Else x < X0 or r >= W: border 214/114/3AB.
  - Else black key: y < Y_SPLIT and rr in [20,39] C#, [50,69] D#, [110,129] F#, [140,159] G#, [170,189] A#. Idle colour 000/000/000.
  - Else separator: (r mod 30 == 29) or (r mod 30 == 0 and r != 0). Colour 000/000/000.
  - Else white key: white index = r div 30 within the octave, mapped to C,D,E,F,G,A,B. Idle colour 3FF/3FF/3FF.
- Key state colour, applied to black and white key areas only (never to separators):
  - key_down[i] = 1 -> 000/3FF/000.
  - hold[i] != 0 -> 000/1FF/000.
  - Otherwise the idle colour.
- Pipeline:
  - Stage 1 registers the region class and key index.
  - Stage 2 reads key_down/hold from the same cycle and registers the RGB.
  - Latency is exactly 2 clocks. The pipeline runs every cycle; rgb_valid tracks px_valid.
  - The RGB value when rgb_valid = 0 is don't-care.
- A key-state update is visible to any pixel whose stage 2 occurs after the update cycle.

Test Plan:
- Bytes 1E at (x=30,y=200): rgb 000/3FF/000 two clocks after px_valid, and key_down[1]=1. At (x=20,y=300): rgb 3FF/3FF/3FF.
- Make 16, then 4A (key 35): key_down[0] and key_down[35] both 1. Pixels (20,300) and (620,300) both green.
- HOLD_FRAMES=8, make 1E then F0 1E: key_down[1]=0 and (30,200) shows 000/1FF/000. After 8 frame_ticks it shows 000/000/000. F0 1E coincident with a frame_tick leaves hold=8.
- E0 F0 1E after a make of 1E: key_down[1] stays 1. E0 1E does not set key_down[1].
- OCTAVES=2, byte 1C: key_down unchanged. Pixel (500,300) gives border 214/114/3AB. Pixel (5,100) gives background.
- Make 25, then pulse resetn=0 mid-glow: all outputs 0 asynchronously. After release, pixel (60,200) is 000/000/000 and (34,300) (separator) is 000/000/000.
